// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single-port synchronous RAM
// One transaction in flight at a time; Gnt/Done/mem_* are all registered outputs of the FSM.
module mem_arbiter #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    input  logic          i_w0,
    input  logic          i_w1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_done0,
    output logic          o_done1,
    output logic [DW-1:0] o_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_data,
    output logic          o_mem_wren,
    input  logic [DW-1:0] i_mem_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAITQ  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_owner;
    logic          r_w;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_done0;
    logic          r_done1;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_data;
    logic          r_mem_wren;

    logic          w_pick1;
    logic          w_any_req;
    logic          w_win_w;

    // Requester 1 wins alone, or on a tie when requester 0 was served last.
    assign w_any_req = i_req0 | i_req1;
    assign w_pick1   = i_req1 & (~i_req0 | ~r_last);
    assign w_win_w   = w_pick1 ? i_w1 : i_w0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_w        <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wren <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    if (w_any_req) begin
                        r_owner    <= w_pick1;
                        r_last     <= w_pick1;
                        r_w        <= w_win_w;
                        r_mem_addr <= w_pick1 ? i_addr1 : i_addr0;
                        r_mem_data <= w_pick1 ? i_wdata1 : i_wdata0;
                        r_mem_wren <= w_win_w;
                        r_gnt0     <= ~w_pick1;
                        r_gnt1     <= w_pick1;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_wren <= 1'b0;
                    if (r_w) begin
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_WAITQ;
                    end
                end
                ST_WAITQ: begin
                    // RAM output reflects the address presented during ACCESS.
                    r_rdata <= i_mem_q;
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_done0    = r_done0;
    assign o_done1    = r_done1;
    assign o_rdata    = r_rdata;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_mem_wren = r_mem_wren;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// A behavioural synchronous RAM sits behind the arbiter; expected values are hand-computed.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        w0, w1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] ram [256];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_wren)
            ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    mem_arbiter #(.DW(16), .AW(8)) dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_addr0    (addr0),
        .i_addr1    (addr1),
        .i_wdata0   (wdata0),
        .i_wdata1   (wdata1),
        .i_w0       (w0),
        .i_w1       (w1),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_done0    (done0),
        .o_done1    (done1),
        .o_rdata    (rdata),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_wren (mem_wren),
        .i_mem_q    (mem_q)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0; w0 = 0; w1 = 0;
        pre_we = 1'b1; pre_addr = 8'h05; pre_data = 16'hBEEF;
        step();
        pre_we = 1'b0;
        step();
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_rdata", rdata, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mdata", mem_data, 0);
        reset = 1'b0;

        // read from requester 0
        req0 = 1; addr0 = 8'h05; w0 = 0; wdata0 = 16'hFFFF;
        step();
        check("rd0_acc_gnt0", gnt0, 1);
        check("rd0_acc_gnt1", gnt1, 0);
        check("rd0_acc_addr", mem_addr, 8'h05);
        check("rd0_acc_wren", mem_wren, 0);
        check("rd0_acc_done", done0, 0);
        step();
        check("rd0_wq_gnt0", gnt0, 1);
        check("rd0_wq_done", done0, 0);
        step();
        check("rd0_resp_done0", done0, 1);
        check("rd0_resp_done1", done1, 0);
        check("rd0_resp_gnt0", gnt0, 1);
        check("rd0_resp_rdata", rdata, 16'hBEEF);
        req0 = 0;
        step();
        check("rd0_idle_done", done0, 0);
        check("rd0_idle_gnt", gnt0, 0);
        check("rd0_idle_rdata", rdata, 16'hBEEF);

        // write from requester 1, data changed after grant
        req1 = 1; addr1 = 8'h10; wdata1 = 16'h1234; w1 = 1;
        step();
        check("wr1_acc_gnt1", gnt1, 1);
        check("wr1_acc_gnt0", gnt0, 0);
        check("wr1_acc_wren", mem_wren, 1);
        check("wr1_acc_addr", mem_addr, 8'h10);
        check("wr1_acc_data", mem_data, 16'h1234);
        check("wr1_acc_done", done1, 0);
        wdata1 = 16'hDEAD; addr1 = 8'h33;
        step();
        check("wr1_resp_done1", done1, 1);
        check("wr1_resp_wren", mem_wren, 0);
        check("wr1_resp_gnt1", gnt1, 1);
        req1 = 0;
        step();
        check("wr1_idle_done", done1, 0);
        check("wr1_idle_wren", mem_wren, 0);
        check("wr1_idle_addr_hold", mem_addr, 8'h10);
        check("wr1_ram", ram[8'h10], 16'h1234);

        // read back via requester 1
        req1 = 1; addr1 = 8'h10; w1 = 0;
        step(); step(); step();
        check("rb1_done1", done1, 1);
        check("rb1_rdata", rdata, 16'h1234);
        req1 = 0;
        step();

        // contention: fresh reset, both held, grants must alternate 0,1,0,1
        reset = 1;
        step();
        reset = 0;
        req0 = 1; req1 = 1; w0 = 0; w1 = 0; addr0 = 8'h05; addr1 = 8'h10;
        for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("rr%0d_gnt0", t), gnt0, (t % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_gnt1", t), gnt1, (t % 2 == 1) ? 1 : 0);
            step();
            check($sformatf("rr%0d_overlap", t), gnt0 & gnt1, 0);
            step();
            check($sformatf("rr%0d_done", t), {done0, done1}, (t % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("rr%0d_rdata", t), rdata, (t % 2 == 0) ? 16'hBEEF : 16'h1234);
            step();
            check($sformatf("rr%0d_idle", t), {gnt0, gnt1, done0, done1}, 0);
        end
        req0 = 0; req1 = 0;
        step();

        // reset during ACCESS of a write
        req0 = 1; w0 = 1; addr0 = 8'h20; wdata0 = 16'h5555;
        step();
        check("rst_mid_wren_pre", mem_wren, 1);
        reset = 1; req0 = 0;
        step();
        check("rst_mid_wren", mem_wren, 0);
        check("rst_mid_gnt", {gnt0, gnt1}, 0);
        check("rst_mid_done", {done0, done1}, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_data", mem_data, 0);
        check("rst_mid_rdata", rdata, 0);
        reset = 0;
        step(); step();
        check("rst_mid_after_done", {done0, done1}, 0);
        check("rst_mid_after_gnt", {gnt0, gnt1, mem_wren}, 0);

        // churn during WAITQ: original address must be used, single Done
        req1 = 1; w1 = 0; addr1 = 8'h05;
        step(); step();
        req1 = 0; addr1 = 8'h10; w1 = 1;
        step();
        check("churn_done1", done1, 1);
        check("churn_rdata", rdata, 16'hBEEF);
        step();
        check("churn_done_once", done1, 0);
        step();
        check("churn_quiet", {gnt1, done1}, 0);

        // back-to-back from requester 0
        req0 = 1; w0 = 0; addr0 = 8'h10;
        step(); step(); step();
        check("b2b_done_a", done0, 1);
        check("b2b_rdata_a", rdata, 16'h1234);
        step();
        check("b2b_idle", {gnt0, done0}, 0);
        addr0 = 8'h05;
        step();
        check("b2b_regrant", gnt0, 1);
        check("b2b_addr", mem_addr, 8'h05);
        step(); step();
        check("b2b_done_b", done0, 1);
        check("b2b_rdata_b", rdata, 16'hBEEF);
        req0 = 0;
        step();
        check("b2b_end_done", done0, 0);
        step();
        check("b2b_end_gnt", gnt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 16, data width of requester and memory data paths.
REQ-002 Parameter: AW, 8, memory word-address width.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Req0 / Req1  input  1 each  access request from requester 0 / 1; held high until the matching Done pulse.
REQ-006 Addr0 / Addr1  input  AW each  word address of the request; sampled only at grant.
REQ-007 Wdata0 / Wdata1  input  DW each  write data; sampled only at grant.
REQ-008 W0 / W1  input  1 each  1 = write, 0 = read; sampled only at grant.
REQ-009 Gnt0 / Gnt1  output  1 each  high from ACCESS through RESP of the owning requester's transaction.
REQ-010 Done0 / Done1  output  1 each  one-cycle completion pulse to the owner.
REQ-011 Rdata  output  DW  read data; valid only while a Done is high on a read.
REQ-012 mem_addr  output  AW  address to the single-port synchronous RAM.
REQ-013 mem_data  output  DW  write data to the RAM.
REQ-014 mem_wren  output  1  RAM write enable.
REQ-015 mem_q  input  DW  RAM read data, valid one clock after the address edge.

Function
REQ-016 FSM states: IDLE, ACCESS, WAITQ, RESP; exactly one transaction is in flight at any time.
REQ-017 IDLE: if neither Req is high, stay in IDLE; otherwise latch the winner's Addr, Wdata, W and owner id, then go to ACCESS.
REQ-018 Arbitration: a single requesting side wins outright; when both request, the side not served last wins (round-robin).
REQ-019 The last-served pointer updates when the transaction enters ACCESS; the reset value selects requester 0 first on a tie.
REQ-020 ACCESS (1 cycle): drive mem_addr/mem_data from the latched values and mem_wren = latched W.
REQ-021 From ACCESS, a write goes to RESP and a read goes to WAITQ.
REQ-022 WAITQ (1 cycle): capture mem_q into the Rdata register, then go to RESP.
REQ-023 RESP (1 cycle): assert the owner's Done, keep Rdata stable, then return to IDLE.
REQ-024 Latency from Req sampled high in IDLE to the Done cycle: read = 3 clocks, write = 2 clocks.
REQ-025 mem_wren is high only in ACCESS with W = 1; it is never high in any other state.
REQ-026 Gnt and Done are never high for both requesters in the same cycle.
REQ-027 Req dropping mid-transaction is ignored; the transaction completes and Done still pulses.
REQ-028 Addr, Wdata and W changes after grant do not affect the in-flight transaction.
REQ-029 The requester drops Req in the cycle after Done. A Req still high when the FSM is back in IDLE is a new request and is arbitrated normally.
REQ-030 Outside a read's RESP cycle, Rdata holds its last captured value.
REQ-031 mem_addr/mem_data hold their last driven values when idle.

Reset
REQ-032 While Reset is high at an edge: state goes to IDLE and last-served points to 1; Gnt0/1, Done0/1 and mem_wren are 0; Rdata, mem_addr and mem_data are 0.
REQ-033 Reset mid-transaction aborts it: no Done is issued, no further write occurs, and the FSM leaves IDLE only on Req after Reset falls.

Verification
REQ-034 Read from requester 0: RAM[0x05] = 0xBEEF, Req0 = 1, W0 = 0, Addr0 = 0x05 -> Gnt0 high 3 cycles, Done0 pulses on the 3rd clock after sampling, Rdata = 0xBEEF.
REQ-035 Write from requester 1: Addr1 = 0x10, Wdata1 = 0x1234, W1 = 1 -> mem_wren high exactly 1 cycle with mem_addr = 0x10 and mem_data = 0x1234; Done1 on the 2nd clock; a subsequent read returns 0x1234.
REQ-036 Contention: Req0 and Req1 held continuously with each re-request after Done -> grants alternate 0,1,0,1 starting with 0 after reset; Gnt0 and Gnt1 never overlap.
REQ-037 Reset mid-op: Reset asserted in ACCESS of a write -> no Done; mem_wren is 0 from the reset edge onward; outputs are 0 after reset.
REQ-038 Input churn: Req1 dropped and Addr1 changed during WAITQ -> the original address's data is returned and Done1 still pulses once.
REQ-039 Back-to-back: Req0 kept high after Done0 with Req1 low -> a new transaction starts from IDLE with no lost or merged Done.
